// File: rtl/sum_tx_sequencer.sv
// Debounces the A/B save buttons, strobes the operand latch, then sends the sum as ASCII hex over the UART.
// Define SUM_TX_SEQ_CRLF_EN to append CR/LF to each frame.
module sum_tx_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic [4:0] sum,
  input  logic       tx_busy,
  output logic       load_a,
  output logic       load_b,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       seq_busy,
  output logic       frame_done
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
`ifdef SUM_TX_SEQ_CRLF_EN
  localparam int IDX_W    = 2;
  localparam int LAST_IDX = 3;
`else
  localparam int IDX_W    = 1;
  localparam int LAST_IDX = 1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SEND,
    WAIT_DONE
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] frame_byte(input logic [4:0] s, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = hex_ascii({3'b000, s[4]});
    if (idx == IDX_W'(1)) b = hex_ascii(s[3:0]);
`ifdef SUM_TX_SEQ_CRLF_EN
    if (idx == IDX_W'(2)) b = 8'h0D;
    if (idx == IDX_W'(3)) b = 8'h0A;
`endif
    return b;
  endfunction

  logic [1:0] w_btn_n;
  logic [1:0] w_press;

  assign w_btn_n = {save_b_n, save_a_n};

  // Bit 0 is button A, bit 1 is button B; each path is sync -> debounce -> falling-edge detect.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic [SYNC_STAGES-1:0] r_sync;
      logic [CNT_W-1:0]       r_cnt;
      logic                   r_deb;
      logic                   r_deb_d;
      logic                   r_press;
      logic                   w_synced;

      assign w_synced   = r_sync[SYNC_STAGES-1];
      assign w_press[gi] = r_press;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_sync  <= '1;
          r_cnt   <= '0;
          r_deb   <= 1'b1;
          r_deb_d <= 1'b1;
          r_press <= 1'b0;
        end else begin
          r_sync  <= {r_sync[SYNC_STAGES-2:0], w_btn_n[gi]};
          r_deb_d <= r_deb;
          r_press <= r_deb_d & ~r_deb;
          if (w_synced != r_deb) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
              r_deb <= w_synced;
              r_cnt <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_cnt <= '0;
          end
        end
      end
    end
  endgenerate

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_idx, w_idx_next;
  logic [SET_W-1:0] r_settle_cnt, w_settle_next;
  logic [4:0]       r_sum_q, w_sum_q_next;
  logic             r_have_a, w_have_a_next;
  logic             r_have_b, w_have_b_next;
  logic             r_load_a, w_load_a_next;
  logic             r_load_b, w_load_b_next;
  logic             r_tx_en, w_tx_en_next;
  logic [7:0]       r_tx_data, w_tx_data_next;
  logic             r_seq_busy, w_seq_busy_next;
  logic             r_frame_done, w_frame_done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_settle_cnt <= '0;
      r_sum_q      <= '0;
      r_have_a     <= 1'b0;
      r_have_b     <= 1'b0;
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_tx_en      <= 1'b0;
      r_tx_data    <= 8'h00;
      r_seq_busy   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_settle_cnt <= w_settle_next;
      r_sum_q      <= w_sum_q_next;
      r_have_a     <= w_have_a_next;
      r_have_b     <= w_have_b_next;
      r_load_a     <= w_load_a_next;
      r_load_b     <= w_load_b_next;
      r_tx_en      <= w_tx_en_next;
      r_tx_data    <= w_tx_data_next;
      r_seq_busy   <= w_seq_busy_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_settle_next     = r_settle_cnt;
    w_sum_q_next      = r_sum_q;
    w_have_a_next     = r_have_a;
    w_have_b_next     = r_have_b;
    w_load_a_next     = 1'b0;
    w_load_b_next     = 1'b0;
    w_tx_en_next      = r_tx_en;
    w_tx_data_next    = r_tx_data;
    w_seq_busy_next   = r_seq_busy;
    w_frame_done_next = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_press[0]) begin
          w_load_a_next = 1'b1;
          w_have_a_next = 1'b1;
        end
        if (w_press[1]) begin
          w_load_b_next = 1'b1;
          w_have_b_next = 1'b1;
        end
        if (r_have_a && r_have_b) begin
          w_state_next    = SETTLE;
          w_settle_next   = '0;
          w_seq_busy_next = 1'b1;
        end
      end
      SETTLE: begin
        // Give the latch and adder time to settle before the sum is captured.
        if (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
          w_sum_q_next   = sum;
          w_idx_next     = '0;
          w_tx_en_next   = 1'b1;
          w_tx_data_next = frame_byte(sum, '0);
          w_state_next   = SEND;
        end else begin
          w_settle_next = r_settle_cnt + SET_W'(1);
        end
      end
      SEND: begin
        if (tx_busy) begin
          w_tx_en_next = 1'b0;
          w_state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_idx == IDX_W'(LAST_IDX)) begin
            w_frame_done_next = 1'b1;
            w_have_a_next     = 1'b0;
            w_have_b_next     = 1'b0;
            w_seq_busy_next   = 1'b0;
            w_state_next      = IDLE;
          end else begin
            w_idx_next     = r_idx + IDX_W'(1);
            w_tx_en_next   = 1'b1;
            w_tx_data_next = frame_byte(r_sum_q, r_idx + IDX_W'(1));
            w_state_next   = SEND;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign load_a     = r_load_a;
  assign load_b     = r_load_b;
  assign tx_en      = r_tx_en;
  assign tx_data    = r_tx_data;
  assign seq_busy   = r_seq_busy;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Scoreboard bench for sum_tx_sequencer: a UART model captures each accepted byte; tests compare them
// against bytes pushed when the sum and button presses are driven.
module tb_sum_tx_sequencer;
  localparam int SYNC     = 2;
  localparam int DC       = 16;
  localparam int ST       = 2;
  localparam int LAT      = SYNC + DC + 1;
  localparam int BUSY_CYC = 12;
`ifdef SUM_TX_SEQ_CRLF_EN
  localparam int FLEN = 4;
`else
  localparam int FLEN = 2;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       save_a_n = 1'b1;
  logic       save_b_n = 1'b1;
  logic [4:0] sum = 5'h00;
  logic       tx_busy = 1'b0;
  logic       load_a, load_b, tx_en, seq_busy, frame_done;
  logic [7:0] tx_data;

  sum_tx_sequencer #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .SETTLE_CYCLES(ST)
  ) dut (
    .clk(clk), .reset(reset), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .sum(sum), .tx_busy(tx_busy), .load_a(load_a), .load_b(load_b),
    .tx_en(tx_en), .tx_data(tx_data), .seq_busy(seq_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor and UART model (busy for BUSY_CYC cycles per accepted byte).
  int         la_cnt = 0, lb_cnt = 0, la_cyc = 0, lb_cyc = 0, both_cnt = 0;
  int         fd_cnt = 0, late_cnt = 0, busy_left = 0, sb_rise_cyc = 0;
  bit         ack_prev = 1'b0, sb_prev = 1'b0;
  logic [7:0] obs_q[$];

  always @(negedge clk) begin
    if (load_a) begin la_cnt <= la_cnt + 1; la_cyc <= cyc; end
    if (load_b) begin lb_cnt <= lb_cnt + 1; lb_cyc <= cyc; end
    if (load_a && load_b) both_cnt <= both_cnt + 1;
    if (frame_done) fd_cnt <= fd_cnt + 1;
    if (seq_busy && !sb_prev) sb_rise_cyc <= cyc;
    sb_prev <= seq_busy;
    if (ack_prev && tx_en) late_cnt <= late_cnt + 1;
    ack_prev <= (busy_left == 0) && tx_en && !tx_busy;
    if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) tx_busy <= 1'b0;
    end else if (tx_en && !tx_busy) begin
      obs_q.push_back(tx_data);
      tx_busy   <= 1'b1;
      busy_left <= BUSY_CYC;
    end
  end

  int         n_checks = 0, n_pass = 0, rd_idx = 0;
  logic [7:0] exp_q[$];

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [4:0] s);
    exp_q.push_back(hexc({3'b000, s[4]}));
    exp_q.push_back(hexc(s[3:0]));
`ifdef SUM_TX_SEQ_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic press(input bit a, input bit b, input int hold, output int t0);
    if (a) save_a_n = 1'b0;
    if (b) save_b_n = 1'b0;
    t0 = cyc + 1;
    tick(hold);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    tick(LAT + 3);
  endtask

  task automatic wait_obs(input int n, input int bound);
    for (int i = 0; i < bound && obs_q.size() < n; i++) tick(1);
  endtask

  task automatic wait_fd(input int target, input int bound);
    for (int i = 0; i < bound && fd_cnt < target; i++) tick(1);
  endtask

  task automatic test_reset();
    tick(3);
    n_checks++; if (load_a !== 1'b0) $display("FAIL reset load_a: got %b expected 0", load_a); else n_pass++;
    n_checks++; if (load_b !== 1'b0) $display("FAIL reset load_b: got %b expected 0", load_b); else n_pass++;
    n_checks++; if (tx_en !== 1'b0) $display("FAIL reset tx_en: got %b expected 0", tx_en); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset tx_data: got %h expected 00", tx_data); else n_pass++;
    n_checks++; if (seq_busy !== 1'b0) $display("FAIL reset seq_busy: got %b expected 0", seq_busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b expected 0", frame_done); else n_pass++;
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_frame_1e();
    int t0, la0, lb0, fd0;
    logic [7:0] e, g;
    sum = 5'h1E;
    exp_q.push_back(8'h31);
    exp_q.push_back(8'h45);
`ifdef SUM_TX_SEQ_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    la0 = la_cnt; lb0 = lb_cnt; fd0 = fd_cnt;
    press(1'b1, 1'b0, 40, t0);
    n_checks++; if (la_cnt !== la0 + 1) $display("FAIL frame_1e load_a count: got %0d expected %0d", la_cnt, la0 + 1); else n_pass++;
    n_checks++; if (la_cyc !== t0 + LAT) $display("FAIL frame_1e load_a latency: got cycle %0d expected %0d", la_cyc, t0 + LAT); else n_pass++;
    press(1'b0, 1'b1, 40, t0);
    n_checks++; if (lb_cnt !== lb0 + 1) $display("FAIL frame_1e load_b count: got %0d expected %0d", lb_cnt, lb0 + 1); else n_pass++;
    n_checks++; if (lb_cyc !== t0 + LAT) $display("FAIL frame_1e load_b latency: got cycle %0d expected %0d", lb_cyc, t0 + LAT); else n_pass++;
    wait_obs(rd_idx + FLEN, 300);
    wait_fd(fd0 + 1, 100);
    tick(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL frame_1e byte: got none expected %h", e);
      else begin
        g = obs_q[rd_idx]; rd_idx++;
        if (g !== e) $display("FAIL frame_1e byte: got %h expected %h", g, e);
        else begin n_pass++; $display("frame_1e tx byte %h", g); end
      end
    end
    n_checks++; if (fd_cnt !== fd0 + 1) $display("FAIL frame_1e frame_done count: got %0d expected %0d", fd_cnt, fd0 + 1); else n_pass++;
    n_checks++; if (late_cnt !== 0) $display("FAIL frame_1e tx_en after ack: got %0d late cycles expected 0", late_cnt); else n_pass++;
    n_checks++; if (seq_busy !== 1'b0) $display("FAIL frame_1e seq_busy after frame: got %b expected 0", seq_busy); else n_pass++;
  endtask

  task automatic test_zero_nine();
    int t0, fd0;
    logic [7:0] e, g;
    logic [4:0] vals [2];
    vals[0] = 5'h00; vals[1] = 5'h09;
    for (int k = 0; k < 2; k++) begin
      sum = vals[k];
      push_frame(vals[k]);
      fd0 = fd_cnt;
      press(1'b1, 1'b0, 25, t0);
      press(1'b0, 1'b1, 25, t0);
      wait_obs(rd_idx + FLEN, 300);
      wait_fd(fd0 + 1, 100);
      tick(5);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); n_checks++;
        if (rd_idx >= obs_q.size()) $display("FAIL zero_nine byte: got none expected %h", e);
        else begin
          g = obs_q[rd_idx]; rd_idx++;
          if (g !== e) $display("FAIL zero_nine byte: got %h expected %h", g, e);
          else begin n_pass++; $display("zero_nine tx byte %h", g); end
        end
      end
      n_checks++; if (fd_cnt !== fd0 + 1) $display("FAIL zero_nine frame_done count: got %0d expected %0d", fd_cnt, fd0 + 1); else n_pass++;
    end
    n_checks++; if (late_cnt !== 0) $display("FAIL zero_nine tx_en after ack: got %0d late cycles expected 0", late_cnt); else n_pass++;
  endtask

  task automatic test_bounce();
    int t0, la0;
    la0 = la_cnt;
    save_a_n = 1'b0;
    tick(DC - 2);
    save_a_n = 1'b1;
    tick(LAT + 5);
    n_checks++; if (la_cnt !== la0) $display("FAIL bounce short pulse load_a: got %0d expected %0d", la_cnt, la0); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      save_a_n = ~save_a_n;
      tick(3);
    end
    save_a_n = 1'b1;
    tick(LAT + 5);
    n_checks++; if (la_cnt !== la0) $display("FAIL bounce toggling load_a: got %0d expected %0d", la_cnt, la0); else n_pass++;
    press(1'b1, 1'b0, 30, t0);
    n_checks++; if (la_cnt !== la0 + 1) $display("FAIL bounce stable load_a: got %0d expected %0d", la_cnt, la0 + 1); else n_pass++;
    n_checks++; if (la_cyc !== t0 + LAT) $display("FAIL bounce stable latency: got cycle %0d expected %0d", la_cyc, t0 + LAT); else n_pass++;
  endtask

  // Operand A is already held from test_bounce; B starts the frame, then A is pressed mid-frame.
  task automatic test_ignore_press();
    int t0, la0, lb0, fd0;
    logic [7:0] e, g;
    sum = 5'h13;
    push_frame(5'h13);
    la0 = la_cnt; fd0 = fd_cnt;
    save_b_n = 1'b0;
    wait_obs(rd_idx + 1, 100);
    save_a_n = 1'b0;
    tick(30);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    tick(LAT + 3);
    wait_obs(rd_idx + FLEN, 300);
    wait_fd(fd0 + 1, 100);
    tick(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL ignore_press byte: got none expected %h", e);
      else begin
        g = obs_q[rd_idx]; rd_idx++;
        if (g !== e) $display("FAIL ignore_press byte: got %h expected %h", g, e);
        else begin n_pass++; $display("ignore_press tx byte %h", g); end
      end
    end
    n_checks++; if (la_cnt !== la0) $display("FAIL ignore_press load_a mid-frame: got %0d expected %0d", la_cnt, la0); else n_pass++;
    n_checks++; if (fd_cnt !== fd0 + 1) $display("FAIL ignore_press frame_done count: got %0d expected %0d", fd_cnt, fd0 + 1); else n_pass++;
    lb0 = lb_cnt;
    press(1'b0, 1'b1, 25, t0);
    tick(60);
    n_checks++; if (lb_cnt !== lb0 + 1) $display("FAIL ignore_press lone B load_b: got %0d expected %0d", lb_cnt, lb0 + 1); else n_pass++;
    n_checks++; if (obs_q.size() !== rd_idx) $display("FAIL ignore_press lone B bytes: got %0d expected %0d", obs_q.size(), rd_idx); else n_pass++;
    n_checks++; if (fd_cnt !== fd0 + 1) $display("FAIL ignore_press lone B frame_done: got %0d expected %0d", fd_cnt, fd0 + 1); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int t0, fd0;
    logic [7:0] e, g;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    sum = 5'h0A;
    exp_q.push_back(hexc(4'h0));
    fd0 = fd_cnt;
    press(1'b1, 1'b0, 25, t0);
    save_b_n = 1'b0;
    wait_obs(rd_idx + 1, 100);
    tick(1);
    reset = 1'b1;
    save_b_n = 1'b1;
    tick(1);
    n_checks++; if (tx_en !== 1'b0) $display("FAIL reset_mid tx_en: got %b expected 0", tx_en); else n_pass++;
    n_checks++; if (seq_busy !== 1'b0) $display("FAIL reset_mid seq_busy: got %b expected 0", seq_busy); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL reset_mid tx_data: got %h expected 00", tx_data); else n_pass++;
    reset = 1'b0;
    tick(60);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL reset_mid byte: got none expected %h", e);
      else begin
        g = obs_q[rd_idx]; rd_idx++;
        if (g !== e) $display("FAIL reset_mid byte: got %h expected %h", g, e);
        else begin n_pass++; $display("reset_mid tx byte %h", g); end
      end
    end
    n_checks++; if (fd_cnt !== fd0) $display("FAIL reset_mid frame_done: got %0d expected %0d", fd_cnt, fd0); else n_pass++;
    n_checks++; if (obs_q.size() !== rd_idx) $display("FAIL reset_mid extra bytes: got %0d expected %0d", obs_q.size(), rd_idx); else n_pass++;
    push_frame(5'h0A);
    press(1'b1, 1'b0, 25, t0);
    press(1'b0, 1'b1, 25, t0);
    wait_obs(rd_idx + FLEN, 300);
    wait_fd(fd0 + 1, 100);
    tick(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL reset_mid refill byte: got none expected %h", e);
      else begin
        g = obs_q[rd_idx]; rd_idx++;
        if (g !== e) $display("FAIL reset_mid refill byte: got %h expected %h", g, e);
        else begin n_pass++; $display("reset_mid refill tx byte %h", g); end
      end
    end
    n_checks++; if (fd_cnt !== fd0 + 1) $display("FAIL reset_mid refill frame_done: got %0d expected %0d", fd_cnt, fd0 + 1); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int t0, b0, fd0;
    logic [7:0] e, g;
    sum = 5'h17;
    push_frame(5'h17);
    b0 = both_cnt; fd0 = fd_cnt;
    press(1'b1, 1'b1, 30, t0);
    n_checks++; if (both_cnt !== b0 + 1) $display("FAIL simult both strobes: got %0d expected %0d", both_cnt, b0 + 1); else n_pass++;
    n_checks++; if (la_cyc !== t0 + LAT) $display("FAIL simult load_a latency: got cycle %0d expected %0d", la_cyc, t0 + LAT); else n_pass++;
    n_checks++; if (lb_cyc !== t0 + LAT) $display("FAIL simult load_b latency: got cycle %0d expected %0d", lb_cyc, t0 + LAT); else n_pass++;
    n_checks++; if (sb_rise_cyc !== t0 + LAT + 1) $display("FAIL simult settle entry: got cycle %0d expected %0d", sb_rise_cyc, t0 + LAT + 1); else n_pass++;
    wait_obs(rd_idx + FLEN, 300);
    wait_fd(fd0 + 1, 100);
    tick(5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n_checks++;
      if (rd_idx >= obs_q.size()) $display("FAIL simult byte: got none expected %h", e);
      else begin
        g = obs_q[rd_idx]; rd_idx++;
        if (g !== e) $display("FAIL simult byte: got %h expected %h", g, e);
        else begin n_pass++; $display("simult tx byte %h", g); end
      end
    end
    n_checks++; if (fd_cnt !== fd0 + 1) $display("FAIL simult frame_done: got %0d expected %0d", fd_cnt, fd0 + 1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame_1e();
    test_zero_nine();
    test_bounce();
    test_ignore_press();
    test_reset_midframe();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
